// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with run-time CPOL/CPHA and NUM_CS active-low selects.
// A frame runs SETUP (CS low, SCLK idle), XFER (DATA_W SCLK periods) and HOLD
// (CS kept low), then returns to IDLE with a one-cycle done pulse.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to add a 'loopback' input that
// feeds MOSI back into the receive shifter and keeps every CS line high.
module spi_master_multi #(
  parameter int  DATA_W  = 32,
  parameter int  CLK_DIV = 2,
  parameter int  NUM_CS  = 4,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              SPI_SCLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic [NUM_CS-1:0] SPI_CS
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int HC_W  = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HC_W-1:0]     hcnt_q, hcnt_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, done_q, done_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rxsh_q, rxsh_d, rx_q, rx_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;
  logic                sin;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q, lb_d;
  assign sin = lb_q ? mosi_q : SPI_MISO;
`else
  assign sin = SPI_MISO;
`endif

  // Next-state and datapath: everything is computed here and registered below.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    lb_d    = lb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          div_d   = '0;
          hcnt_d  = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          sclk_d  = cpol;
          rxsh_d  = '0;
          // Out-of-range cs_sel matches no line, so the frame runs unselected.
          cs_d    = '1;
          for (int i = 0; i < NUM_CS; i++)
            if (cs_sel == CS_W'(i)) cs_d[i] = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
          lb_d = loopback;
          if (loopback) cs_d = '1;
`endif
          // cpha=0 presents the MSB before the first edge; cpha=1 waits for it.
          if (cpha) begin
            tx_d = tx_data;
          end else begin
            mosi_d = tx_data[DATA_W-1];
            tx_d   = tx_data << 1;
          end
        end
      end
      SETUP: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          hcnt_d = hcnt_q + 1'b1;
          // Leading edge leaves the idle level; it samples when cpha=0, shifts when cpha=1.
          if ((sclk_q == cpol_q) != cpha_q) begin
            rxsh_d = {rxsh_q[DATA_W-2:0], sin};
          end else begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (hcnt_q == HC_W'(2 * DATA_W - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        // CLK_DIV+1 cycles: one half-period of CS hold plus the registered done edge.
        div_d = div_q + 1'b1;
        if (div_q == DIV_W'(CLK_DIV)) begin
          state_d = IDLE;
          div_d   = '0;
          cs_d    = '1;
          rx_d    = rxsh_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      hcnt_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rxsh_q  <= '0;
      rx_q    <= '0;
      cs_q    <= '1;
      done_q  <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q    <= lb_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS   = cs_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: random and directed frames on a 32-bit and an 8-bit master,
// checked against a behavioural SPI slave plus the frame timing/CS rules.
module tb_spi_master_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic        st32 = 0, pol32 = 0, pha32 = 0, busy32, done32, sclk32, mosi32;
  logic        miso32 = 0;
  logic [1:0]  sel32 = 0;
  logic [31:0] tx32 = 0, rx32;
  logic [3:0]  cs32;
  logic        st8 = 0, pol8 = 0, pha8 = 0, busy8, done8, sclk8, mosi8;
  logic        miso8 = 0;
  logic [1:0]  sel8 = 0;
  logic [7:0]  tx8 = 0, rx8;
  logic [2:0]  cs8;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic        lb32 = 0, lb8 = 0;
`endif

  spi_master_multi #(.DATA_W(32), .CLK_DIV(2), .NUM_CS(4)) dut (
    .clk(clk), .rst(rst_n), .start(st32), .cpol(pol32), .cpha(pha32), .cs_sel(sel32),
    .tx_data(tx32), .rx_data(rx32), .busy(busy32), .done(done32),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lb32),
`endif
    .SPI_SCLK(sclk32), .SPI_MOSI(mosi32), .SPI_MISO(miso32), .SPI_CS(cs32));

  spi_master_multi #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(3)) dut8 (
    .clk(clk), .rst(rst_n), .start(st8), .cpol(pol8), .cpha(pha8), .cs_sel(sel8),
    .tx_data(tx8), .rx_data(rx8), .busy(busy8), .done(done8),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lb8),
`endif
    .SPI_SCLK(sclk8), .SPI_MOSI(mosi8), .SPI_MISO(miso8), .SPI_CS(cs8));

  // Behavioural slave: watches the selected DUT's lines once per cycle.
  bit          s_use8 = 0, s_cpol = 0, s_cpha = 0;
  int          s_w = 32, s_idx = -1;
  logic [31:0] s_sh = 0, s_rx = 0;
  logic        p_sc = 0, p_csl = 0;
  always @(negedge clk) begin : slave
    logic sc, mo, csl, b;
    sc  = s_use8 ? sclk8 : sclk32;
    mo  = s_use8 ? mosi8 : mosi32;
    csl = 1'b0;
    if (s_idx >= 0) csl = s_use8 ? !cs8[s_idx] : !cs32[s_idx];
    if (csl && !p_csl && !s_cpha) begin
      b = s_sh[s_w-1]; s_sh = s_sh << 1;
      if (s_use8) miso8 = b; else miso32 = b;
    end else if (csl && p_csl && sc !== p_sc) begin
      if ((sc != s_cpol) != s_cpha) begin
        s_rx = {s_rx[30:0], mo};
      end else begin
        b = s_sh[s_w-1]; s_sh = s_sh << 1;
        if (s_use8) miso8 = b; else miso32 = b;
      end
    end else if (!csl && p_csl) begin
      if (s_use8) miso8 = 1'b0; else miso32 = 1'b0;
    end
    p_sc  = sc;
    p_csl = csl;
  end

  // Starts one frame (caller is 1 time unit after a rising edge) and follows it to done.
  task automatic do_frame(input bit u8, input bit pol, input bit pha, input logic [1:0] sel,
      input logic [31:0] tx, input logic [31:0] sw, input int sidx, input int rp,
      output int lat, output logic [3:0] cs_and, output logic [3:0] cs_or,
      output logic sclk_first, output logic busy_first, output logic [31:0] rx_first,
      output bit rx_stable);
    logic [3:0]  cs_now;
    logic [31:0] rx_now;
    s_use8 = u8; s_w = u8 ? 8 : 32; s_cpol = pol; s_cpha = pha; s_idx = sidx;
    s_sh = sw; s_rx = '0;
    if (u8) begin st8 = 1; pol8 = pol; pha8 = pha; sel8 = sel; tx8 = tx[7:0]; end
    else begin st32 = 1; pol32 = pol; pha32 = pha; sel32 = sel; tx32 = tx; end
    @(posedge clk); #1;
    st8 = 0; st32 = 0;
    sclk_first = u8 ? sclk8 : sclk32;
    busy_first = u8 ? busy8 : busy32;
    rx_first   = u8 ? {24'h0, rx8} : rx32;
    rx_stable  = 1'b1;
    lat = -1; cs_and = '1; cs_or = '0;
    for (int k = 1; k <= 400; k++) begin
      cs_now = u8 ? {1'b1, cs8} : cs32;
      rx_now = u8 ? {24'h0, rx8} : rx32;
      cs_and &= cs_now;
      cs_or  |= cs_now;
      if (rx_now !== rx_first) rx_stable = 1'b0;
      if (u8) st8 = (k == rp); else st32 = (k == rp);
      if (k == rp) begin tx8 = '1; tx32 = '1; end
      @(posedge clk); #1;
      if (u8 ? done8 : done32) begin lat = k; break; end
    end
    st8 = 0; st32 = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy32 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy32); end
    checks++; if (done32 !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done32); end
    checks++; if (rx32 !== 32'h0) begin errs++; $display("FAIL reset_rx: got %h want 0", rx32); end
    checks++; if ({sclk32, mosi32} !== 2'b00) begin errs++; $display("FAIL reset_sclk_mosi: got %b want 00", {sclk32, mosi32}); end
    checks++; if (cs32 !== 4'hF) begin errs++; $display("FAIL reset_cs: got %b want 1111", cs32); end
    checks++; if (cs8 !== 3'b111) begin errs++; $display("FAIL reset_cs8: got %b want 111", cs8); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mode0;
    int lat; logic [3:0] ca, co; logic s0, b0; logic [31:0] r0; bit rs;
    @(posedge clk); #1;
    do_frame(0, 0, 0, 2'd0, 32'h12345678, 32'hFEDCBA98, 0, -1, lat, ca, co, s0, b0, r0, rs);
    checks++; if (lat != 133) begin errs++; $display("FAIL mode0_latency: got %0d want 133", lat); end
    checks++; if (rx32 !== 32'hFEDCBA98) begin errs++; $display("FAIL mode0_rx: got %h want fedcba98", rx32); end
    checks++; if (s_rx !== 32'h12345678) begin errs++; $display("FAIL mode0_slave_rx: got %h want 12345678", s_rx); end
    checks++; if ({ca, co} !== 8'hEE) begin errs++; $display("FAIL mode0_cs: got %b/%b want 1110", ca, co); end
    checks++; if ({busy32, b0} !== 2'b01) begin errs++; $display("FAIL mode0_busy: got done-cycle %b accept %b want 0/1", busy32, b0); end
    @(posedge clk); #1;
    checks++; if (done32 !== 1'b0) begin errs++; $display("FAIL mode0_done_width: got %b want 0", done32); end
  endtask

  task automatic test_mode3_w8;
    int lat; logic [3:0] ca, co; logic s0, b0; logic [31:0] r0; bit rs;
    @(posedge clk); #1;
    do_frame(1, 1, 1, 2'd0, 32'hA5, 32'h3C, 0, -1, lat, ca, co, s0, b0, r0, rs);
    checks++; if (lat != 37) begin errs++; $display("FAIL mode3_latency: got %0d want 37", lat); end
    checks++; if (rx8 !== 8'h3C) begin errs++; $display("FAIL mode3_rx: got %h want 3c", rx8); end
    checks++; if (s_rx[7:0] !== 8'hA5) begin errs++; $display("FAIL mode3_slave_rx: got %h want a5", s_rx[7:0]); end
    checks++; if ({s0, sclk8} !== 2'b11) begin errs++; $display("FAIL mode3_sclk_idle: got %b want 11", {s0, sclk8}); end
    checks++; if (busy8 !== 1'b0) begin errs++; $display("FAIL mode3_busy: got %b want 0", busy8); end
  endtask

  task automatic test_cs_select;
    int lat; logic [3:0] ca, co; logic s0, b0; logic [31:0] r0, tx, sw; bit rs;
    bit pol, pha;
    tx = $urandom; sw = $urandom; pol = 1'($urandom); pha = 1'($urandom);
    @(posedge clk); #1;
    do_frame(0, pol, pha, 2'd2, tx, sw, 2, -1, lat, ca, co, s0, b0, r0, rs);
    checks++; if ({ca, co} !== 8'hBB) begin errs++; $display("FAIL cs2_lines: got %b/%b want 1011", ca, co); end
    checks++; if (rx32 !== sw || s_rx !== tx) begin errs++; $display("FAIL cs2_data: got %h/%h want %h/%h", rx32, s_rx, sw, tx); end
    @(posedge clk); #1;
    do_frame(1, pol, pha, 2'd3, tx, sw, -1, -1, lat, ca, co, s0, b0, r0, rs);
    checks++; if ({ca, co} !== 8'hFF) begin errs++; $display("FAIL cs_oob_lines: got %b/%b want 1111", ca, co); end
    checks++; if (lat != 37) begin errs++; $display("FAIL cs_oob_done: got %0d want 37", lat); end
    checks++; if (rx8 !== 8'h00) begin errs++; $display("FAIL cs_oob_rx: got %h want 00", rx8); end
  endtask

  task automatic test_start_ignored;
    int lat, extra; logic [3:0] ca, co; logic s0, b0; logic [31:0] r0, tx, sw; bit rs;
    tx = $urandom; sw = $urandom; extra = 0;
    @(posedge clk); #1;
    do_frame(0, 0, 0, 2'd1, tx, sw, 1, 50, lat, ca, co, s0, b0, r0, rs);
    checks++; if (lat != 133) begin errs++; $display("FAIL ign_latency: got %0d want 133", lat); end
    checks++; if (rx32 !== sw || s_rx !== tx) begin errs++; $display("FAIL ign_data: got %h/%h want %h/%h", rx32, s_rx, sw, tx); end
    repeat (6) begin
      @(posedge clk); #1;
      if (done32 || busy32) extra++;
    end
    checks++; if (extra != 0) begin errs++; $display("FAIL ign_no_second: got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [3:0] ca, co; logic s0, b0; logic [31:0] r0, swa, swb, txb; bit rs;
    swa = $urandom; swb = $urandom; txb = $urandom;
    @(posedge clk); #1;
    do_frame(0, 1, 0, 2'd3, $urandom, swa, 3, -1, lat, ca, co, s0, b0, r0, rs);
    do_frame(0, 0, 1, 2'd0, txb, swb, 0, -1, lat, ca, co, s0, b0, r0, rs);
    checks++; if (b0 !== 1'b1) begin errs++; $display("FAIL b2b_accept: got busy %b want 1", b0); end
    checks++; if (lat != 133) begin errs++; $display("FAIL b2b_latency: got %0d want 133", lat); end
    checks++; if (r0 !== swa || !rs) begin errs++; $display("FAIL b2b_rx_hold: got %h stable=%0d want %h stable=1", r0, rs, swa); end
    checks++; if (rx32 !== swb || s_rx !== txb) begin errs++; $display("FAIL b2b_data: got %h/%h want %h/%h", rx32, s_rx, swb, txb); end
  endtask

  task automatic test_random;
    int lat; logic [3:0] ca, co, csx; logic s0, b0; logic [31:0] r0, tx, sw; bit rs;
    bit pol, pha; logic [1:0] sel;
    for (int n = 0; n < 8; n++) begin
      tx = $urandom; sw = $urandom; pol = 1'($urandom); pha = 1'($urandom);
      sel = 2'($urandom_range(0, 3));
      csx = 4'hF & ~(4'h1 << sel);
      @(posedge clk); #1;
      do_frame(0, pol, pha, sel, tx, sw, int'(sel), -1, lat, ca, co, s0, b0, r0, rs);
      checks++; if (rx32 !== sw) begin errs++; $display("FAIL rnd%0d_rx: got %h want %h", n, rx32, sw); end
      checks++; if (s_rx !== tx) begin errs++; $display("FAIL rnd%0d_slave_rx: got %h want %h", n, s_rx, tx); end
      checks++; if (lat != 133) begin errs++; $display("FAIL rnd%0d_latency: got %0d want 133", n, lat); end
      checks++; if (ca !== csx || co !== csx) begin errs++; $display("FAIL rnd%0d_cs: got %b/%b want %b", n, ca, co, csx); end
      checks++; if (s0 !== pol || sclk32 !== pol) begin errs++; $display("FAIL rnd%0d_sclk_idle: got %b/%b want %b", n, s0, sclk32, pol); end
    end
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback;
    int lat; logic [3:0] ca, co; logic s0, b0; logic [31:0] r0; bit rs;
    @(posedge clk); #1;
    lb32 = 1'b1;
    do_frame(0, 0, 1, 2'd1, 32'hDEADBEEF, $urandom, -1, -1, lat, ca, co, s0, b0, r0, rs);
    lb32 = 1'b0;
    checks++; if (rx32 !== 32'hDEADBEEF) begin errs++; $display("FAIL loopback_rx: got %h want deadbeef", rx32); end
    checks++; if ({ca, co} !== 8'hFF) begin errs++; $display("FAIL loopback_cs: got %b/%b want 1111", ca, co); end
  endtask
`endif

  task automatic test_reset_midframe;
    int dones;
    dones = 0;
    @(posedge clk); #1;
    s_use8 = 0; s_w = 32; s_cpol = 1; s_cpha = 0; s_idx = 1; s_sh = $urandom; s_rx = '0;
    st32 = 1; pol32 = 1; pha32 = 0; sel32 = 2'd1; tx32 = $urandom;
    @(posedge clk); #1;
    st32 = 0;
    repeat (42) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (cs32 !== 4'hF || sclk32 !== 1'b0) begin errs++; $display("FAIL rstmid_lines: got cs %b sclk %b want 1111/0", cs32, sclk32); end
    checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin errs++; $display("FAIL rstmid_busy_done: got %b/%b want 0/0", busy32, done32); end
    checks++; if (rx32 !== 32'h0 || mosi32 !== 1'b0) begin errs++; $display("FAIL rstmid_rx_mosi: got %h/%b want 0/0", rx32, mosi32); end
    #3 rst_n = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      if (done32 || busy32) dones++;
    end
    checks++; if (dones != 0) begin errs++; $display("FAIL rstmid_no_done: got %0d busy/done cycles want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_w8();
    test_cs_select();
    test_start_ignored();
    test_back_to_back();
    test_random();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
